fp32_iterative_divider: RTL and testbench
=========================================

# fp32_iterative_divider

Multi-cycle IEEE-754 binary32 divider for the FPU, alongside the pipelined FP32 adder. It computes `lhs / rhs` with a radix-2 restoring mantissa loop and round-to-nearest-even. It handles subnormal inputs and outputs and returns the same canonical NaN as the adder. It uses a valid/ready request handshake and a one-cycle result pulse, and holds one operation in flight.

## Interface
- `ITER_BITS`, 25: quotient bits produced, being 24 significand bits plus 1 guard bit. Fixed for binary32; not meant to be overridden.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: request valid.
- `lhs` in 32: dividend, sampled when `req & ready`.
- `rhs` in 32: divisor, sampled when `req & ready`.
- `flush` in 1: synchronous abort of any in-flight operation.
- `ready` out 1: high only in IDLE.
- `result_valid` out 1: one-cycle pulse.
- `result` out 32: quotient, registered, held until the next pulse.

## Operation
- **States:** IDLE, PREP, ITER, ROUND, DONE.
  - IDLE → PREP on `req`.
  - PREP → DONE when the operation is a special case.
  - PREP → ITER otherwise.
  - ITER stays for 25 cycles, then → ROUND.
  - ROUND → DONE.
  - DONE → IDLE.
- **PREP, operand prep:**
  - Sign = `lhs[31]^rhs[31]`.
  - Subnormal inputs are normalized with a leading-zero count to a mantissa in [1,2). Their exponent becomes `1-lz`, held as a signed 10-bit value.
  - If mant_a < mant_b, mant_a is shifted left by 1 and its exponent is decremented.
  - Exponent e = ea − eb + 127, signed 10-bit.
- **Special cases,** resolved in PREP with priority top-down:
  - Either input NaN → 0x7fc00000.
  - inf/inf → 0x7fc00000.
  - 0/0 → 0x7fc00000.
  - inf/x → ±inf.
  - x/0 with x≠0 → ±inf.
  - 0/x → ±0.
  - x/inf → ±0.
- **ITER:**
  - Each cycle: rem' = rem − div. If the result is non-negative, the q bit is 1 and rem'' = rem'. Otherwise the q bit is 0 and rem'' = rem.
  - Then rem = rem''<<1.
  - This yields 25 bits q[24:0] with q[24]=1.
  - Sticky = (final remainder ≠ 0).
- **ROUND:**
  - If e ≥ 255 → ±inf.
  - If e ≤ 0 → denormalize: shift `{q,sticky}` right by 1−e, OR-ing the shifted-out bits into sticky.
    - A shift ≥ 26 leaves only sticky.
    - The exponent field is 0.
  - RNE: increment when guard & (lsb | sticky).
  - A mantissa carry increments the exponent field. This covers subnormal→min-normal and max-normal→inf (0x7f800000 with sign).
- **Exact zero:** an exact zero result after underflow keeps the computed sign.
- **flush:**
  - Takes effect at the next edge from any state.
  - The FSM goes to IDLE; no `result_valid`; `result` is unchanged.
  - `req` in the same cycle as `flush` is ignored.

## Timing
- **Reset** (async assert, sync release):
  - state = IDLE.
  - `ready` = 1.
  - `result_valid` = 0.
  - `result` = 0x00000000.
  - Loop registers are cleared.
- **Handshake:**
  - The request is accepted at edge T0 when `req & ready`.
  - `ready` falls after T0 and stays 0 until DONE.
  - `req` while not ready is ignored and not queued.
- **Latency, normal path:** `result_valid` is high for one cycle after edge T0+28.
  - PREP 1 cycle, ITER 25, ROUND 1, DONE 1.
- **Latency, special case:** `result_valid` is high after edge T0+2.
- **Back-to-back:**
  - `ready` is 1 in the cycle after the `result_valid` pulse.
  - Throughput is 1 operation per 29 cycles on the normal path.
- **Reset mid-operation:** drops the operation immediately; no result.
- **Output stability:** `result` changes only on the edge that raises `result_valid`.

## Test plan
- 0x40c00000 / 0x40000000 (6/2) → `result_valid` at T0+28, 0x40400000.
- 0x3f800000 / 0x40400000 (1/3) → 0x3eaaaaab, exercising RNE round-up. Then issue back-to-back 0x3f800000 / 0x3f800000 → 0x3f800000 at 29-cycle spacing.
- Specials at T0+2:
  - 0x3f800000/0x00000000 → 0x7f800000.
  - 0x00000000/0x00000000 → 0x7fc00000.
  - 0xff800000/0x40000000 → 0xff800000.
  - 0x7fa00000/0x3f800000 → 0x7fc00000.
- Range:
  - 0x7f7fffff/0x3f000000 → 0x7f800000.
  - 0x00800000/0x40000000 → 0x00400000.
  - 0x00000001/0x00000001 → 0x3f800000.
  - 0x00000001/0x40800000 → 0x00000000.
- Tie and carry:
  - 0x00000003/0x40000000 → 0x00000002 (tie to even).
  - 0x00ffffff/0x40000000 → 0x00800000 (round carry into min-normal).
- Control:
  - Assert `flush` at T0+10 → no pulse, `ready` back at T0+11.
  - Drop `rst_n` at T0+5 → outputs return to reset values immediately.
  - A new 6/2 request after either → correct 0x40400000.

Source files
------------

// File: rtl/fp32_iterative_divider.sv
// fp32_iterative_divider: multi-cycle IEEE-754 binary32 divider.
// Radix-2 restoring mantissa loop (one quotient bit per cycle), round-to-nearest-even,
// full subnormal support, canonical quiet NaN 0x7fc00000. One operation in flight.
module fp32_iterative_divider #(
  parameter int ITER_BITS = 25  // 24 significand bits + 1 guard bit
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] lhs_i,
  input  logic [31:0] rhs_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        result_valid_o,
  output logic [31:0] result_o
);

  localparam logic [31:0] QNAN = 32'h7fc00000;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_e;

  typedef struct packed {
    logic signed [9:0] e;  // biased exponent, may go below 1 for normalized subnormals
    logic [23:0]       m;  // significand in [1,2) with the hidden bit at [23]
  } unp_t;

  // Leading-zero count of a 24-bit vector (24 when the vector is zero).
  function automatic logic [4:0] clz24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Split an operand into a normalized significand and signed exponent.
  function automatic unp_t unpack(input logic [31:0] x);
    unp_t       u;
    logic [4:0] lz;
    lz = clz24({1'b0, x[22:0]});
    if (x[30:23] != 8'd0) begin
      u.m = {1'b1, x[22:0]};
      u.e = $signed({2'b00, x[30:23]});
    end else begin
      u.m = {1'b0, x[22:0]} << lz;
      u.e = 10'sd1 - $signed({5'd0, lz});
    end
    return u;
  endfunction

  state_e                 state_q, state_d;
  logic [31:0]            a_q, a_d, b_q, b_d;
  logic                   sign_q, sign_d;
  logic signed [9:0]      exp_q, exp_d;
  logic [23:0]            div_q, div_d;
  logic [25:0]            rem_q, rem_d;
  logic [ITER_BITS-1:0]   quo_q, quo_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [31:0]            res_q, res_d;
  logic [31:0]            result_q, result_d;
  logic                   result_valid_q, result_valid_d;

  // Operand classification and special-case result, decoded from the captured operands.
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, op_sign;
  logic        spec_hit;
  logic [31:0] spec_res;

  // Resolve special operand combinations in priority order.
  always_comb begin
    a_nan    = (a_q[30:23] == 8'hff) && (a_q[22:0] != 23'd0);
    b_nan    = (b_q[30:23] == 8'hff) && (b_q[22:0] != 23'd0);
    a_inf    = (a_q[30:23] == 8'hff) && (a_q[22:0] == 23'd0);
    b_inf    = (b_q[30:23] == 8'hff) && (b_q[22:0] == 23'd0);
    a_zero   = (a_q[30:0] == 31'd0);
    b_zero   = (b_q[30:0] == 31'd0);
    op_sign  = a_q[31] ^ b_q[31];
    spec_hit = 1'b1;
    spec_res = QNAN;
    if (a_nan || b_nan)        spec_res = QNAN;
    else if (a_inf && b_inf)   spec_res = QNAN;
    else if (a_zero && b_zero) spec_res = QNAN;
    else if (a_inf)            spec_res = {op_sign, 8'hff, 23'd0};
    else if (b_zero)           spec_res = {op_sign, 8'hff, 23'd0};
    else if (a_zero)           spec_res = {op_sign, 31'd0};
    else if (b_inf)            spec_res = {op_sign, 31'd0};
    else                       spec_hit = 1'b0;
  end

  // Significand alignment so the quotient lands in [1,2), plus the result exponent.
  unp_t              ua, ub;
  logic [24:0]       ma_al;
  logic signed [9:0] ea_al, exp_new;

  // Normalize both operands and pre-shift the dividend when it is the smaller significand.
  always_comb begin
    ua = unpack(a_q);
    ub = unpack(b_q);
    if (ua.m < ub.m) begin
      ma_al = {ua.m, 1'b0};
      ea_al = ua.e - 10'sd1;
    end else begin
      ma_al = {1'b0, ua.m};
      ea_al = ua.e;
    end
    exp_new = ea_al - ub.e + 10'sd127;
  end

  // One restoring-division step: trial subtract, keep or restore, shift.
  logic [26:0] trial;
  logic        qbit;
  logic [25:0] rem_keep;

  always_comb begin
    trial    = {1'b0, rem_q} - {3'b000, div_q};
    qbit     = ~trial[26];
    rem_keep = qbit ? trial[25:0] : rem_q;
  end

  // Overflow, denormalization and round-to-nearest-even of the finished quotient.
  logic signed [9:0] sh;
  logic [23:0]       qs;
  logic              lost, guard, sticky_all, inc;
  logic [30:0]       base;
  logic [31:0]       round_res;

  always_comb begin
    sh         = 10'sd1 - exp_q;
    qs         = '0;
    lost       = 1'b0;
    guard      = 1'b0;
    sticky_all = |rem_q;
    base       = '0;
    inc        = 1'b0;
    if (exp_q >= 10'sd255) begin
      round_res = {sign_q, 8'hff, 23'd0};
    end else begin
      if (exp_q <= 10'sd0) begin
        // Result is subnormal: move the quotient down to the 2^-149 grid.
        if (sh >= 10'sd25) begin
          qs   = '0;
          lost = |quo_q;
        end else begin
          qs   = 24'(quo_q >> sh[4:0]);
          lost = |(quo_q & ~({ITER_BITS{1'b1}} << sh[4:0]));
        end
        base       = {8'd0, qs[23:1]};
        guard      = qs[0];
        sticky_all = (|rem_q) | lost;
      end else begin
        base  = {exp_q[7:0], quo_q[23:1]};
        guard = quo_q[0];
      end
      // A carry out of the mantissa field bumps the exponent field for free.
      inc       = guard & (base[0] | sticky_all);
      round_res = {sign_q, base + 31'(inc)};
    end
  end

  // Next-state logic; flush overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (req_i) state_d = S_PREP;
        S_PREP:  state_d = spec_hit ? S_DONE : S_ITER;
        S_ITER:  if (cnt_q == 5'(ITER_BITS - 1)) state_d = S_ROUND;
        S_ROUND: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next-state: capture, prep, iterate, round, publish.
  always_comb begin
    a_d            = a_q;
    b_d            = b_q;
    sign_d         = sign_q;
    exp_d          = exp_q;
    div_d          = div_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    cnt_d          = cnt_q;
    res_d          = res_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i && !flush_i) begin
          a_d = lhs_i;
          b_d = rhs_i;
        end
      end
      S_PREP: begin
        sign_d = op_sign;
        if (spec_hit) begin
          res_d = spec_res;
        end else begin
          exp_d = exp_new;
          rem_d = {1'b0, ma_al};
          div_d = ub.m;
          quo_d = '0;
          cnt_d = '0;
        end
      end
      S_ITER: begin
        rem_d = rem_keep << 1;
        quo_d = {quo_q[ITER_BITS-2:0], qbit};
        cnt_d = cnt_q + 5'd1;
      end
      S_ROUND: begin
        res_d = round_res;
      end
      S_DONE: begin
        if (!flush_i) begin
          result_d       = res_q;
          result_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      a_q            <= '0;
      b_q            <= '0;
      sign_q         <= 1'b0;
      exp_q          <= '0;
      div_q          <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      cnt_q          <= '0;
      res_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      sign_q         <= sign_d;
      exp_q          <= exp_d;
      div_q          <= div_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      cnt_q          <= cnt_d;
      res_q          <= res_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign ready_o        = (state_q == S_IDLE);
  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;

endmodule

// File: tb/tb_fp32_iterative_divider.sv
// Self-checking bench for fp32_iterative_divider: directed cases with known answers,
// flush and reset control, then random operands against an exact rational reference.
module tb_fp32_iterative_divider;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic        flush;
  logic        ready;
  logic        result_valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  fp32_iterative_divider dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .lhs_i          (lhs),
    .rhs_i          (rhs),
    .flush_i        (flush),
    .ready_o        (ready),
    .result_valid_o (result_valid),
    .result_o       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {is_special, result}. Quotient computed as an exact scaled integer ratio,
  // then rounded to nearest-even on the binary32 grid (normal or 2^-149 subnormal step).
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic         sign, an, bn, ai, bi, az, bz;
    logic [127:0] ma, mb, q, r, kept, lowmask, one;
    int           ea, eb, scale, p, be, lsbexp, drop;
    logic         guard, sticky, inc;
    longint       bits;
    sign = a[31] ^ b[31];
    an = (a[30:23] == 8'hff) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hff) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hff) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hff) && (b[22:0] == 0);
    az = (a[30:0] == 0);
    bz = (b[30:0] == 0);
    if (an || bn)      return {1'b1, 32'h7fc00000};
    if (ai && bi)      return {1'b1, 32'h7fc00000};
    if (az && bz)      return {1'b1, 32'h7fc00000};
    if (ai || bz)      return {1'b1, sign, 8'hff, 23'd0};
    if (az || bi)      return {1'b1, sign, 31'd0};
    one = 128'd1;
    ma  = {104'd0, (a[30:23] != 0), a[22:0]};
    mb  = {104'd0, (b[30:23] != 0), b[22:0]};
    ea  = ((a[30:23] == 0) ? 1 : int'(a[30:23])) - 150;
    eb  = ((b[30:23] == 0) ? 1 : int'(b[30:23])) - 150;
    q   = (ma << 60) / mb;
    r   = (ma << 60) % mb;
    scale = ea - eb - 60;
    p = 127;
    while (p > 0 && q[p] == 1'b0) p--;
    be = p + scale + 127;
    if (be >= 255) return {1'b0, sign, 8'hff, 23'd0};
    lsbexp = (be >= 1) ? (p + scale - 23) : -149;
    drop   = lsbexp - scale;
    if (drop > 120) begin
      kept   = '0;
      guard  = 1'b0;
      sticky = 1'b1;
    end else begin
      kept    = q >> drop;
      guard   = q[drop-1];
      lowmask = (one << (drop - 1)) - one;
      sticky  = ((q & lowmask) != 0) || (r != 0);
    end
    inc  = guard & (kept[0] | sticky);
    bits = (longint'((be >= 1) ? be : 1) - 1) * 64'd8388608 + longint'(kept[63:0]) + longint'(inc);
    if (bits >= 64'h7f800000) bits = 64'h7f800000;
    return {1'b0, sign, bits[30:0]};
  endfunction

  function automatic logic [31:0] gen_op();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: ;
      1: x[30:23] = 8'($urandom_range(117, 137));
      2: x[30:23] = 8'd0;
      3: x[30:23] = 8'($urandom_range(1, 20));
      4: x[30:23] = 8'($urandom_range(235, 254));
      default: begin
        case ($urandom_range(0, 3))
          0:       x = {x[31], 31'd0};
          1:       x = {x[31], 8'hff, 23'd0};
          2:       x = {x[31], 8'hff, x[22:1], 1'b1};
          default: x = {x[31], 31'h7f7fffff};
        endcase
      end
    endcase
    return x;
  endfunction

  // Issue one request (starting just after an edge), wait a bounded time for the pulse,
  // then check latency and result. Returns the acceptance edge time.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, output time t0);
    int   k;
    logic seen;
    chk({tag, " ready"}, 32'(ready), 32'd1);
    req = 1'b1;
    lhs = a;
    rhs = b;
    @(posedge clk);
    t0 = $time;
    #1;
    req = 1'b0;
    chk({tag, " busy"}, 32'(ready), 32'd0);
    k    = 0;
    seen = 1'b0;
    while (k < 40 && !seen) begin
      @(posedge clk);
      k++;
      #1;
      if (result_valid) seen = 1'b1;
    end
    chk({tag, " latency"}, 32'(k), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    $display("[TB] %s: %h / %h -> %h (want %h) after %0d cycles", tag, a, b, result, exp_res, k);
  endtask

  initial begin
    time         t_a, t_b;
    logic [32:0] refv;
    logic [31:0] ra, rb;
    int          pulses;

    rst_n = 1'b0;
    req   = 1'b0;
    flush = 1'b0;
    lhs   = '0;
    rhs   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset valid", 32'(result_valid), 32'd0);
    chk("reset result", result, 32'h00000000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Main function, normal path latency, RNE, back-to-back spacing.
    run_op("6/2", 32'h40c00000, 32'h40000000, 32'h40400000, 28, t_a);
    run_op("1/3", 32'h3f800000, 32'h40400000, 32'h3eaaaaab, 28, t_a);
    run_op("1/1 b2b", 32'h3f800000, 32'h3f800000, 32'h3f800000, 28, t_b);
    chk("b2b spacing", 32'((t_b - t_a) / 10), 32'd29);
    @(posedge clk);
    #1;
    chk("pulse width", 32'(result_valid), 32'd0);
    chk("result held", result, 32'h3f800000);

    // Special cases.
    run_op("1/0", 32'h3f800000, 32'h00000000, 32'h7f800000, 2, t_a);
    run_op("0/0", 32'h00000000, 32'h00000000, 32'h7fc00000, 2, t_a);
    run_op("-inf/2", 32'hff800000, 32'h40000000, 32'hff800000, 2, t_a);
    run_op("snan/1", 32'h7fa00000, 32'h3f800000, 32'h7fc00000, 2, t_a);

    // Range and rounding boundaries.
    run_op("ovf", 32'h7f7fffff, 32'h3f000000, 32'h7f800000, 28, t_a);
    run_op("minnorm/2", 32'h00800000, 32'h40000000, 32'h00400000, 28, t_a);
    run_op("dmin/dmin", 32'h00000001, 32'h00000001, 32'h3f800000, 28, t_a);
    run_op("dmin/4", 32'h00000001, 32'h40800000, 32'h00000000, 28, t_a);
    run_op("tie even", 32'h00000003, 32'h40000000, 32'h00000002, 28, t_a);
    run_op("carry minnorm", 32'h00ffffff, 32'h40000000, 32'h00800000, 28, t_a);
    run_op("6/2 ref", 32'h40c00000, 32'h40000000, 32'h40400000, 28, t_a);

    // Flush mid-operation, then flush together with a request while idle.
    req = 1'b1;
    lhs = 32'h3f800000;
    rhs = 32'h40400000;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush ready", 32'(ready), 32'd1);
    req   = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    req   = 1'b0;
    flush = 1'b0;
    chk("flush+req ignored", 32'(ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) pulses++;
    end
    chk("flush no pulse", 32'(pulses), 32'd0);
    chk("flush result kept", result, 32'h40400000);
    $display("[TB] flush: ready=%0d pulses=%0d result=%h", ready, pulses, result);
    run_op("6/2 after flush", 32'h40c00000, 32'h40000000, 32'h40400000, 28, t_a);

    // Reset in the middle of an operation.
    req = 1'b1;
    lhs = 32'h3f800000;
    rhs = 32'h40400000;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset ready", 32'(ready), 32'd1);
    chk("midreset valid", 32'(result_valid), 32'd0);
    chk("midreset result", result, 32'h00000000);
    $display("[TB] mid-op reset: ready=%0d valid=%0d result=%h", ready, result_valid, result);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (result_valid) pulses++;
    end
    chk("midreset no pulse", 32'(pulses), 32'd0);
    run_op("6/2 after reset", 32'h40c00000, 32'h40000000, 32'h40400000, 28, t_a);

    // Random operands against the reference.
    for (int n = 0; n < 40; n++) begin
      ra   = gen_op();
      rb   = gen_op();
      refv = ref_div(ra, rb);
      run_op($sformatf("rand%0d", n), ra, rb, refv[31:0], refv[32] ? 2 : 28, t_a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
